// File: rtl/uart_rx_ctrl.sv
// UART receiver: 3-sample majority vote per bit, optional parity, 1 or 2 stop bits.
// Latency: result reported one cycle after the mid+1 sample of the last stop bit.
// No backpressure: DATA_VALID/PAR_ERR/STP_ERR/BREAK are single-cycle pulses.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_ctrl #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               STOP2,
    input  logic [PRESC_W-1:0] PRESCALE,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               DATA_VALID,
    output logic               PAR_ERR,
    output logic               STP_ERR,
    output logic               BREAK,
    output logic               BUSY
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]   BONE     = BIT_W'(1);
    localparam logic [PRESC_W-1:0] ONE      = PRESC_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, REPORT} state_t;

    state_t             state;
    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] presc_q;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shreg;
    logic               par_en_q, par_typ_q, stop2_q;
    logic               stop_idx;
    logic               s0, s1;
    logic               par_err_q, stp_err_q;

    logic [PRESC_W-1:0] mid, mid_m1, mid_p1, last_edge, edge_nxt;
    logic               wrap, at_m1, at_mid, at_vote, vote, fin_stp, frame_ok;

    assign mid       = presc_q >> 1;
    assign mid_m1    = mid - ONE;
    assign mid_p1    = mid + ONE;
    assign last_edge = presc_q - ONE;
    assign wrap      = (edge_cnt == last_edge);
    assign at_m1     = (edge_cnt == mid_m1);
    assign at_mid    = (edge_cnt == mid);
    assign at_vote   = (edge_cnt == mid_p1);
    assign edge_nxt  = wrap ? '0 : edge_cnt + ONE;

    // Third sample is taken live at edge M+1 so the voted bit is usable that cycle.
    assign vote     = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
    assign fin_stp  = stp_err_q | ~vote;
    assign frame_ok = ~fin_stp & ~par_err_q;

    assign BUSY = (state != IDLE);

`ifdef UART_RX_BREAK_DET_EN
    logic stop1_q, par_bit_q, brk_hold, brk_q, fin_brk;

    assign fin_brk = (shreg == '0) && !(par_en_q && par_bit_q) &&
                     !(stop_idx ? stop1_q : vote);
    assign BREAK   = brk_q;
`else
    assign BREAK = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            presc_q    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx   <= 1'b0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            stop1_q    <= 1'b1;
            par_bit_q  <= 1'b0;
            brk_hold   <= 1'b0;
            brk_q      <= 1'b0;
`endif
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q      <= 1'b0;
`endif
            if (at_m1)  s0 <= RX_IN;
            if (at_mid) s1 <= RX_IN;

            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        // The detecting cycle itself is edge 0 of the start bit.
                        state     <= START;
                        edge_cnt  <= ONE;
                        presc_q   <= PRESCALE;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        stop2_q   <= STOP2;
                        bit_cnt   <= '0;
                        stop_idx  <= 1'b0;
                        par_err_q <= 1'b0;
                        stp_err_q <= 1'b0;
                    end
                end

                START: begin
                    edge_cnt <= edge_nxt;
                    if (at_vote && vote) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end

                DATA: begin
                    edge_cnt <= edge_nxt;
                    if (at_vote) shreg <= {vote, shreg[DATA_W-1:1]};
                    if (wrap) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BONE;
                        end
                    end
                end

                PARITY: begin
                    edge_cnt <= edge_nxt;
                    if (at_vote) begin
                        par_err_q <= vote ^ (^shreg) ^ par_typ_q;
`ifdef UART_RX_BREAK_DET_EN
                        par_bit_q <= vote;
`endif
                    end
                    if (wrap) state <= STOP;
                end

                STOP: begin
                    if (at_vote) begin
                        stp_err_q <= fin_stp;
`ifdef UART_RX_BREAK_DET_EN
                        if (!stop_idx) stop1_q <= vote;
`endif
                    end
                    if (at_vote && !(stop2_q && !stop_idx)) begin
                        state      <= REPORT;
                        edge_cnt   <= '0;
                        DATA_VALID <= frame_ok;
                        if (frame_ok) P_DATA <= shreg;
`ifdef UART_RX_BREAK_DET_EN
                        if (fin_brk) begin
                            brk_q    <= 1'b1;
                            brk_hold <= 1'b1;
                        end else begin
                            PAR_ERR <= par_err_q;
                            STP_ERR <= fin_stp;
                        end
`else
                        PAR_ERR <= par_err_q;
                        STP_ERR <= fin_stp;
`endif
                    end else begin
                        edge_cnt <= edge_nxt;
                        if (wrap) stop_idx <= 1'b1;
                    end
                end

                REPORT: begin
`ifdef UART_RX_BREAK_DET_EN
                    // After a break, stay busy until the line has idled high for a full bit.
                    if (brk_hold) begin
                        if (!RX_IN) begin
                            edge_cnt <= '0;
                        end else if (wrap) begin
                            state    <= IDLE;
                            edge_cnt <= '0;
                            brk_hold <= 1'b0;
                        end else begin
                            edge_cnt <= edge_cnt + ONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end

                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames driven bit by bit, flag pulses counted at negedge.
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          par_en, par_typ, stop2;
    logic [PW-1:0] presc;
    logic [DW-1:0] p_data;
    logic          data_valid, par_err, stp_err, brk, busy;

    int vectors = 0;
    int miscompares = 0;

    int            dv_cnt, pe_cnt, se_cnt, brk_cnt, busy_bad;
    logic [DW-1:0] dv_data;
    logic          prev_dv = 1'b0;

    uart_rx_ctrl #(.DATA_W(DW), .PRESC_W(PW)) dut (
        .CLK(clk), .RST(rst), .RX_IN(rx), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .PRESCALE(presc), .P_DATA(p_data), .DATA_VALID(data_valid),
        .PAR_ERR(par_err), .STP_ERR(stp_err), .BREAK(brk), .BUSY(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_cnt++;
            dv_data = p_data;
        end
        if (par_err === 1'b1) pe_cnt++;
        if (stp_err === 1'b1) se_cnt++;
        if (brk === 1'b1) brk_cnt++;
        if (prev_dv === 1'b1 && busy !== 1'b0) busy_bad++;
        prev_dv = data_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_counts();
        dv_cnt = 0; pe_cnt = 0; se_cnt = 0; brk_cnt = 0; busy_bad = 0;
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pen,
                              input logic pbit, input logic s2, input logic st1,
                              input logic st2);
        hold(1'b0, p);
        for (int i = 0; i < DW; i++) hold(d[i], p);
        if (pen) hold(pbit, p);
        hold(st1, p);
        if (s2) hold(st2, p);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx = 1'b1; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; presc = 6'd8;
        repeat (4) @(negedge clk);
        vectors++; if (p_data !== 8'h00) begin miscompares++; $display("FAIL reset_p_data: got %h want 00", p_data); end
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL reset_par_err: got %b want 0", par_err); end
        vectors++; if (stp_err !== 1'b0) begin miscompares++; $display("FAIL reset_stp_err: got %b want 0", stp_err); end
        vectors++; if (brk !== 1'b0) begin miscompares++; $display("FAIL reset_break: got %b want 0", brk); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b1;
        hold(1'b1, 4);
    endtask

    task automatic test_basic();
        presc = 6'd8; par_en = 1'b0; stop2 = 1'b0;
        clr_counts();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 16);
        vectors++; if (dv_cnt != 1) begin miscompares++; $display("FAIL basic_dv_count: got %0d want 1", dv_cnt); end
        vectors++; if (dv_data !== 8'hA5) begin miscompares++; $display("FAIL basic_dv_data: got %h want a5", dv_data); end
        vectors++; if (p_data !== 8'hA5) begin miscompares++; $display("FAIL basic_p_data: got %h want a5", p_data); end
        vectors++; if (pe_cnt + se_cnt != 0) begin miscompares++; $display("FAIL basic_errors: got %0d want 0", pe_cnt + se_cnt); end
        vectors++; if (busy_bad != 0) begin miscompares++; $display("FAIL basic_busy_after_dv: got %0d want 0", busy_bad); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_parity();
        // even parity, correct bit: 0x3C has four ones -> parity bit 0
        presc = 6'd16; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
        clr_counts();
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 32);
        vectors++; if (dv_cnt != 1 || p_data !== 8'h3C) begin miscompares++; $display("FAIL even_ok: got dv=%0d data=%h want dv=1 data=3c", dv_cnt, p_data); end
        // odd parity at PRESCALE 32: 0x01 has one 1 -> parity bit 0
        presc = 6'd32; par_typ = 1'b1;
        clr_counts();
        send_frame(8'h01, 32, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 64);
        vectors++; if (dv_cnt != 1 || p_data !== 8'h01) begin miscompares++; $display("FAIL odd_ok: got dv=%0d data=%h want dv=1 data=01", dv_cnt, p_data); end
        vectors++; if (pe_cnt != 0) begin miscompares++; $display("FAIL odd_ok_par_err: got %0d want 0", pe_cnt); end
        // wrong parity bit
        presc = 6'd16; par_typ = 1'b0;
        clr_counts();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 32);
        vectors++; if (pe_cnt != 1) begin miscompares++; $display("FAIL par_err_count: got %0d want 1", pe_cnt); end
        vectors++; if (dv_cnt != 0) begin miscompares++; $display("FAIL par_err_dv: got %0d want 0", dv_cnt); end
        vectors++; if (se_cnt != 0) begin miscompares++; $display("FAIL par_err_stp: got %0d want 0", se_cnt); end
        vectors++; if (p_data !== 8'h01) begin miscompares++; $display("FAIL par_err_p_data_kept: got %h want 01", p_data); end
        par_en = 1'b0;
    endtask

    task automatic test_glitch();
        presc = 6'd16;
        clr_counts();
        hold(1'b0, 3);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
        hold(1'b1, 40);
        vectors++; if (dv_cnt + pe_cnt + se_cnt + brk_cnt != 0) begin miscompares++; $display("FAIL glitch_flags: got %0d want 0", dv_cnt + pe_cnt + se_cnt + brk_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_stop2_back_to_back();
        presc = 6'd16; stop2 = 1'b1; par_en = 1'b0;
        clr_counts();
        send_frame(8'h12, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        hold(1'b1, 48);
        vectors++; if (se_cnt != 1) begin miscompares++; $display("FAIL stop2_stp_err: got %0d want 1", se_cnt); end
        vectors++; if (dv_cnt != 1) begin miscompares++; $display("FAIL b2b_dv_count: got %0d want 1", dv_cnt); end
        vectors++; if (p_data !== 8'h55) begin miscompares++; $display("FAIL b2b_p_data: got %h want 55", p_data); end
        stop2 = 1'b0;
    endtask

    task automatic test_latch();
        logic [DW-1:0] d;
        d = 8'hC3;
        presc = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
        clr_counts();
        hold(1'b0, 8);
        presc = 6'd16; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1;
        for (int i = 0; i < DW; i++) hold(d[i], 8);
        hold(1'b1, 24);
        vectors++; if (dv_cnt != 1 || p_data !== 8'hC3) begin miscompares++; $display("FAIL latch_cfg: got dv=%0d data=%h want dv=1 data=c3", dv_cnt, p_data); end
        vectors++; if (pe_cnt + se_cnt != 0) begin miscompares++; $display("FAIL latch_errors: got %0d want 0", pe_cnt + se_cnt); end
        presc = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    endtask

    task automatic test_break();
        presc = 6'd8; par_en = 1'b0; stop2 = 1'b0;
        clr_counts();
        hold(1'b0, 160);
        hold(1'b1, 40);
`ifdef UART_RX_BREAK_DET_EN
        vectors++; if (brk_cnt != 1) begin miscompares++; $display("FAIL break_count: got %0d want 1", brk_cnt); end
        vectors++; if (se_cnt != 0) begin miscompares++; $display("FAIL break_stp_err: got %0d want 0", se_cnt); end
`else
        vectors++; if (brk_cnt != 0) begin miscompares++; $display("FAIL break_tied: got %0d want 0", brk_cnt); end
        vectors++; if (se_cnt < 1) begin miscompares++; $display("FAIL break_stp_err: got %0d want >=1", se_cnt); end
`endif
        vectors++; if (dv_cnt != 0) begin miscompares++; $display("FAIL break_dv: got %0d want 0", dv_cnt); end
        clr_counts();
        send_frame(8'h3A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 16);
        vectors++; if (dv_cnt != 1 || p_data !== 8'h3A) begin miscompares++; $display("FAIL after_break: got dv=%0d data=%h want dv=1 data=3a", dv_cnt, p_data); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        d = 8'h81;
        presc = 6'd8;
        clr_counts();
        hold(1'b0, 8);
        for (int i = 0; i < 4; i++) hold(d[i], 8);
        hold(d[4], 4);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        vectors++; if (p_data !== 8'h00) begin miscompares++; $display("FAIL mid_rst_p_data: got %h want 00", p_data); end
        vectors++; if (busy !== 1'b0 || data_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy_dv: got %b%b want 00", busy, data_valid); end
        vectors++; if (par_err !== 1'b0 || stp_err !== 1'b0 || brk !== 1'b0) begin miscompares++; $display("FAIL mid_rst_flags: got %b%b%b want 000", par_err, stp_err, brk); end
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        hold(1'b1, 16);
        vectors++; if (dv_cnt + pe_cnt + se_cnt + brk_cnt != 0) begin miscompares++; $display("FAIL mid_rst_no_pulses: got %0d want 0", dv_cnt + pe_cnt + se_cnt + brk_cnt); end
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 16);
        vectors++; if (dv_cnt != 1 || p_data !== 8'h81) begin miscompares++; $display("FAIL mid_rst_recover: got dv=%0d data=%h want dv=1 data=81", dv_cnt, p_data); end
    endtask

    initial begin
        clr_counts();
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_stop2_back_to_back();
        test_latch();
        test_break();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
